// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite engine.
// Holds default geometry, default colour keys, edge_hit bit indices and
// the button bundle passed from the top into the motion block.
package sprite_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_SPR_W    = 120;
    localparam int unsigned DEF_SPR_H    = 160;
    localparam int unsigned DEF_RGB_W    = 12;
    localparam int unsigned DEF_ADDR_W   = 15;
    localparam int unsigned DEF_STEP_W   = 4;

    localparam logic [11:0] DEF_KEY_RGB  = 12'hF0F;
    localparam logic [11:0] DEF_BG_RGB   = 12'h000;

    localparam int unsigned COORD_W      = 10;
    localparam int unsigned CMP_W        = 11;
    localparam int unsigned SPEED_W      = 4;
    localparam int unsigned EDGE_W       = 4;

    // edge_hit bit positions: {top, bottom, left, right}
    localparam int unsigned EDGE_RIGHT   = 0;
    localparam int unsigned EDGE_LEFT    = 1;
    localparam int unsigned EDGE_BOTTOM  = 2;
    localparam int unsigned EDGE_TOP     = 3;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_BOUNCE = 1'b1
    } mode_e;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } btn_t;

endpackage

// File: rtl/sprite_motion.sv
// Sprite position, frame divider and bounce direction state.
// Ports: pclk/rst clock and sync reset; tick_i frame tick; mode_i manual/bounce;
// btn_i button levels; speed_i frames per step minus 1; step_i pixels per step;
// pos_x_o/pos_y_o registered top-left corner; edge_hit_o one-cycle reflection pulse.
module sprite_motion
    import sprite_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned SPR_W    = DEF_SPR_W,
    parameter int unsigned SPR_H    = DEF_SPR_H,
    parameter int unsigned STEP_W   = DEF_STEP_W
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               tick_i,
    input  logic               mode_i,
    input  btn_t               btn_i,
    input  logic [SPEED_W-1:0] speed_i,
    input  logic [STEP_W-1:0]  step_i,
    output logic [COORD_W-1:0] pos_x_o,
    output logic [COORD_W-1:0] pos_y_o,
    output logic [EDGE_W-1:0]  edge_hit_o
);

    localparam int unsigned X_MAX = H_ACTIVE - SPR_W;
    localparam int unsigned Y_MAX = V_ACTIVE - SPR_H;
    localparam int unsigned SUM_W = COORD_W + 1;

    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    logic               dir_x_q, dir_x_d;   // 1 = moving right
    logic               dir_y_q, dir_y_d;   // 1 = moving down
    logic [SPEED_W-1:0] div_q, div_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;
    logic               do_step;

    // Candidate moves in each direction, clamped, with limit-crossing flags
    logic [SUM_W-1:0]   x_sum, y_sum;
    logic               x_over, y_over, x_under, y_under;
    logic [COORD_W-1:0] x_inc, x_dec, y_inc, y_dec;

    assign x_sum   = SUM_W'(pos_x_q) + SUM_W'(step_i);
    assign y_sum   = SUM_W'(pos_y_q) + SUM_W'(step_i);
    assign x_over  = x_sum > SUM_W'(X_MAX);
    assign y_over  = y_sum > SUM_W'(Y_MAX);
    assign x_under = SUM_W'(step_i) > SUM_W'(pos_x_q);
    assign y_under = SUM_W'(step_i) > SUM_W'(pos_y_q);
    assign x_inc   = x_over  ? COORD_W'(X_MAX) : x_sum[COORD_W-1:0];
    assign y_inc   = y_over  ? COORD_W'(Y_MAX) : y_sum[COORD_W-1:0];
    assign x_dec   = x_under ? '0 : pos_x_q - COORD_W'(step_i);
    assign y_dec   = y_under ? '0 : pos_y_q - COORD_W'(step_i);

    // Divider and position update; only a step cycle (which lies in vertical
    // blanking) can move the sprite or sample the mode.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        div_d   = div_q;
        edge_d  = '0;
        do_step = 1'b0;

        if (tick_i) begin
            if (div_q == speed_i) begin
                do_step = 1'b1;
                div_d   = '0;
            end else if (div_q > speed_i) begin
                // speed lowered below the running count: restart the count
                div_d   = '0;
            end else begin
                div_d   = div_q + SPEED_W'(1);
            end
        end

        if (do_step) begin
            if (mode_i == MODE_MANUAL) begin
                if (btn_i.right && !btn_i.left)      pos_x_d = x_inc;
                else if (btn_i.left && !btn_i.right) pos_x_d = x_dec;
                if (btn_i.down && !btn_i.up)         pos_y_d = y_inc;
                else if (btn_i.up && !btn_i.down)    pos_y_d = y_dec;
            end else begin
                if (dir_x_q) begin
                    pos_x_d = x_inc;
                    if (x_over) begin
                        dir_x_d            = 1'b0;
                        edge_d[EDGE_RIGHT] = 1'b1;
                    end
                end else begin
                    pos_x_d = x_dec;
                    if (x_under) begin
                        dir_x_d           = 1'b1;
                        edge_d[EDGE_LEFT] = 1'b1;
                    end
                end
                if (dir_y_q) begin
                    pos_y_d = y_inc;
                    if (y_over) begin
                        dir_y_d             = 1'b0;
                        edge_d[EDGE_BOTTOM] = 1'b1;
                    end
                end else begin
                    pos_y_d = y_dec;
                    if (y_under) begin
                        dir_y_d          = 1'b1;
                        edge_d[EDGE_TOP] = 1'b1;
                    end
                end
            end
        end
    end

    // State registers
    always_ff @(posedge pclk) begin
        if (rst) begin
            pos_x_q <= COORD_W'((H_ACTIVE - SPR_W) / 2);
            pos_y_q <= COORD_W'((V_ACTIVE - SPR_H) / 2);
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            div_q   <= '0;
            edge_q  <= '0;
        end else begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
        end
    end

    assign pos_x_o    = pos_x_q;
    assign pos_y_o    = pos_y_q;
    assign edge_hit_o = edge_q;

endmodule

// File: rtl/sprite_engine.sv
// Sprite overlay: ROM address generation, pixel pipeline and motion control.
// Ports: pclk/rst clock and sync reset; valid_i, h_cnt_i, v_cnt_i from the timing
// generator; mode_i and btn_*_i, speed_i, step_i motion controls; rom_addr_o/rom_data_i
// sprite ROM (1-cycle read); pix_rgb_o registered pixel; pos_x_o/pos_y_o sprite
// corner; edge_hit_o {top,bottom,left,right} reflection pulse.
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int unsigned        H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned        V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned        SPR_W    = DEF_SPR_W,
    parameter int unsigned        SPR_H    = DEF_SPR_H,
    parameter int unsigned        RGB_W    = DEF_RGB_W,
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter int unsigned        STEP_W   = DEF_STEP_W,
    parameter logic [RGB_W-1:0]   KEY_RGB  = RGB_W'(DEF_KEY_RGB),
    parameter logic [RGB_W-1:0]   BG_RGB   = RGB_W'(DEF_BG_RGB)
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic [COORD_W-1:0] h_cnt_i,
    input  logic [COORD_W-1:0] v_cnt_i,
    input  logic               mode_i,
    input  logic               btn_up_i,
    input  logic               btn_down_i,
    input  logic               btn_left_i,
    input  logic               btn_right_i,
    input  logic [SPEED_W-1:0] speed_i,
    input  logic [STEP_W-1:0]  step_i,
    output logic [ADDR_W-1:0]  rom_addr_o,
    input  logic [RGB_W-1:0]   rom_data_i,
    output logic [RGB_W-1:0]   pix_rgb_o,
    output logic [COORD_W-1:0] pos_x_o,
    output logic [COORD_W-1:0] pos_y_o,
    output logic [EDGE_W-1:0]  edge_hit_o
);

    logic [COORD_W-1:0] pos_x, pos_y;
    logic               frame_tick;
    logic               in_area;
    btn_t               btn;

    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               valid_dq, valid_dd;
    logic               area_dq, area_dd;
    logic [RGB_W-1:0]   pix_q, pix_d;

    assign btn = '{up: btn_up_i, down: btn_down_i, left: btn_left_i, right: btn_right_i};

    // One cycle per frame, first pixel of the first blanking line
    assign frame_tick = (v_cnt_i == COORD_W'(V_ACTIVE)) && (h_cnt_i == '0);

    // Sprite window test in 11 bits so pos+size never wraps
    assign in_area = (CMP_W'(h_cnt_i) >= CMP_W'(pos_x))
                  && (CMP_W'(h_cnt_i) <  CMP_W'(pos_x) + CMP_W'(SPR_W))
                  && (CMP_W'(v_cnt_i) >= CMP_W'(pos_y))
                  && (CMP_W'(v_cnt_i) <  CMP_W'(pos_y) + CMP_W'(SPR_H));

    sprite_motion #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .SPR_W    (SPR_W),
        .SPR_H    (SPR_H),
        .STEP_W   (STEP_W)
    ) u_motion (
        .pclk       (pclk),
        .rst        (rst),
        .tick_i     (frame_tick),
        .mode_i     (mode_i),
        .btn_i      (btn),
        .speed_i    (speed_i),
        .step_i     (step_i),
        .pos_x_o    (pos_x),
        .pos_y_o    (pos_y),
        .edge_hit_o (edge_hit_o)
    );

    // Address walk and pixel select; valid/area are delayed to line up with rom_data
    always_comb begin
        rom_addr_d = rom_addr_q;
        valid_dd   = valid_i;
        area_dd    = in_area;
        pix_d      = '0;

        if (frame_tick)
            rom_addr_d = '0;
        else if (valid_i && in_area)
            rom_addr_d = rom_addr_q + ADDR_W'(1);

        if (valid_dq) begin
            if (!area_dq || (rom_data_i == KEY_RGB))
                pix_d = BG_RGB;
            else
                pix_d = rom_data_i;
        end
    end

    // Pipeline registers
    always_ff @(posedge pclk) begin
        if (rst) begin
            rom_addr_q <= '0;
            valid_dq   <= 1'b0;
            area_dq    <= 1'b0;
            pix_q      <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            valid_dq   <= valid_dd;
            area_dq    <= area_dd;
            pix_q      <= pix_d;
        end
    end

    assign rom_addr_o = rom_addr_q;
    assign pix_rgb_o  = pix_q;
    assign pos_x_o    = pos_x;
    assign pos_y_o    = pos_y;

endmodule

// File: doc/sprite_engine.md
SPRITE_ENGINE -- requirements
Module: sprite_engine

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-003 Parameter SPR_W, 120, sprite width in pixels.
REQ-004 Parameter SPR_H, 160, sprite height in lines.
REQ-005 Parameter RGB_W, 12, pixel width (4:4:4).
REQ-006 Parameter ADDR_W, 15, ROM address width; SHALL satisfy 2^ADDR_W >= SPR_W*SPR_H.
REQ-007 Parameter STEP_W, 4, width of step-size input.
REQ-008 Parameter KEY_RGB, 12'hF0F, transparent colour key.
REQ-009 Parameter BG_RGB, 12'h000, background colour inside the active area.
REQ-010 pclk  in  1  pixel clock; all logic on its rising edge.
REQ-011 rst  in  1  reset, synchronous, active-high.
REQ-012 valid  in  1  timing generator active-video flag.
REQ-013 h_cnt, v_cnt  in  10 each  current pixel column and line.
REQ-014 mode  in  1  0 = manual, 1 = bounce.
REQ-015 btn_up, btn_down, btn_left, btn_right  in  1 each  debounced level inputs.
REQ-016 speed  in  4  frames per movement step minus 1.
REQ-017 step  in  STEP_W  pixels moved per step; 0 freezes motion.
REQ-018 rom_addr  out  ADDR_W  sprite ROM address; ROM read latency is 1 cycle.
REQ-019 rom_data  in  RGB_W  sprite ROM data.
REQ-020 pix_rgb  out  RGB_W  registered pixel to DAC.
REQ-021 pos_x, pos_y  out  10 each  sprite top-left corner.
REQ-022 edge_hit  out  4  one-cycle pulse {top,bottom,left,right} on a bounce reflection.

Function
REQ-023 in_area SHALL be true when pos_x <= h_cnt < pos_x+SPR_W and pos_y <= v_cnt < pos_y+SPR_H; compares done in 11 bits, no wrap.
REQ-024 rom_addr SHALL increment by 1 each valid cycle with in_area true, hold otherwise, and clear to 0 on the frame tick.
REQ-025 valid and in_area SHALL be delayed one cycle to align with rom_data; pix_rgb latency from h_cnt/v_cnt is 2 cycles.
REQ-026 pix_rgb: valid_d=0 -> 0; valid_d=1, area_d=0 -> BG_RGB; area_d=1 and rom_data==KEY_RGB -> BG_RGB; else rom_data.
REQ-027 Frame tick SHALL be one cycle when v_cnt==V_ACTIVE and h_cnt==0; positions change only on a step cycle, never during active video.
REQ-028 A 4-bit frame divider SHALL count ticks; on a tick with divider==speed it issues a step and clears, otherwise increments; a speed decrease below the count clears it on the next tick.
REQ-029 Limits: X_MAX = H_ACTIVE-SPR_W (520), Y_MAX = V_ACTIVE-SPR_H (320), minimum 0.
REQ-030 Manual step: each pressed button moves step pixels, clamped to [0,MAX]; up+down or left+right together SHALL cancel on that axis; diagonal moves allowed.
REQ-031 Bounce step: move by step in direction dir_x/dir_y; if result passes a limit, clamp to it, invert that direction, pulse the matching edge_hit bit; both axes may reflect on the same step (corner).
REQ-032 Direction registers SHALL persist across mode changes; mode is sampled only on step cycles.
REQ-033 Buttons SHALL be ignored in bounce mode.

Reset
REQ-034 On rst: pos_x=(H_ACTIVE-SPR_W)/2 (260), pos_y=(V_ACTIVE-SPR_H)/2 (160), dir_x=dir_y=+, divider=0, rom_addr=0, pix_rgb=0, edge_hit=0, delay regs 0.
REQ-035 rst asserted mid-frame SHALL take effect next edge; the output resumes correctly from the following frame tick.

Structure
REQ-036 Package sprite_pkg SHALL hold default geometry constants, KEY_RGB/BG_RGB defaults and edge_hit bit indices.
REQ-037 Position/divider/direction logic SHALL be a sub-module sprite_motion; address/pixel pipeline stays in sprite_engine.

Verification
REQ-038 Reset, 640x480 timing, mode=0, no buttons -> pos (260,160); first sprite pixel at h=260,v=160 appears on pix_rgb 2 cycles later with rom_addr 0.
REQ-039 Manual, step=4, speed=0, btn_left held 70 frames -> pos_x 256,252,...,0 then holds at 0; left+right together -> no change.
REQ-040 Bounce, step=7, speed=0, start (260,160) -> pos_x reaches 520 clamped, edge_hit[right] one cycle, then decreases by 7.
REQ-041 speed=3 -> exactly one step per 4 frame ticks; step=0 -> position frozen.
REQ-042 rom_data=KEY_RGB in sprite -> pix_rgb=BG_RGB; blanking -> pix_rgb=0; rom_addr reaches 19199 at sprite end and clears at tick.
REQ-043 Bounce corner: position (519,319), step=2 -> clamp to (520,320), edge_hit = bottom|right, both directions inverted.
